// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// This is the instruction-fetch / instruction-decode pipeline register for the
// MIPS core. It holds the fetched instruction and its PC+4, and it exposes the
// decoded fields to the decode stage. It also finds load-use hazards: it holds
// fetch and sends one bubble into EX.
//
// Ports
//   clk, rst_n      single rising-edge clock, asynchronous active-low reset
//   in_valid        fetch presents a valid instruction
//   in_instr        fetched instruction word
//   in_pc4          PC+4 of the fetched instruction
//   stall           hold request from later stages
//   flush           taken branch/jump; discard the held instruction
//   in_ready        in_instr is accepted at this edge
//   out_valid       the ID register holds a real instruction
//   out_instr       held instruction word
//   out_pc4         held PC+4
//   opcode/rs/rt/rd/funct/imm16  combinational fields of out_instr
//   ext_sign        extension select for Sign_extend (0 zero-, 1 sign-extend)
//   load_use_stall  load-use hazard; EX takes a bubble this cycle
// ---------------------------------------------------------------------------
module if_id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc4,
   input  logic        stall,
   input  logic        flush,
   output logic        in_ready,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc4,
   output logic [5:0]  opcode,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic        ext_sign,
   output logic        load_use_stall
);

   // The load tracker describes the instruction that left ID on the previous
   // edge. A hazard exists only while the tracker holds a load and the
   // instruction in ID reads that load's destination. So the RUN/HAZARD state
   // is implied by the tracker contents, and no separate state register is kept.
   logic        ex_is_load_r;
   logic [4:0]  ex_rt_r;

   logic        rt_reader_s;
   logic        rs_hit_s;
   logic        rt_hit_s;
   logic        hazard_s;
   logic [31:0] cap_instr_s;
   logic        cap_sign_s;

   // Logical-immediate opcodes (andi/ori/xori/lui) zero-extend; all others sign-extend.
   function automatic logic sign_sel(input logic [5:0] op);
      case (op)
         6'h0C, 6'h0D, 6'h0E, 6'h0F: sign_sel = 1'b0;
         default:                    sign_sel = 1'b1;
      endcase
   endfunction

   assign opcode = out_instr[31:26];
   assign rs     = out_instr[25:21];
   assign rt     = out_instr[20:16];
   assign rd     = out_instr[15:11];
   assign funct  = out_instr[5:0];
   assign imm16  = out_instr[15:0];

   // Decide whether the instruction in ID reads rt as a source register.
   always_comb begin
      rt_reader_s = 1'b0;
      case (opcode)
         6'h00, 6'h04, 6'h05, 6'h2B: rt_reader_s = 1'b1;
         default:                    rt_reader_s = 1'b0;
      endcase
   end

   // Load-use detection. $0 is never a real dependency.
   always_comb begin
      rs_hit_s = (ex_rt_r == rs);
      rt_hit_s = rt_reader_s & (ex_rt_r == rt);
      hazard_s = out_valid & ex_is_load_r & (ex_rt_r != 5'd0) & (rs_hit_s | rt_hit_s);
   end

   // Choose the word that an advancing edge captures: a bubble becomes NOP_INSTR.
   always_comb begin
      if (in_valid) begin
         cap_instr_s = in_instr;
      end else begin
         cap_instr_s = NOP_INSTR;
      end
      cap_sign_s = sign_sel(cap_instr_s[31:26]);
   end

   assign load_use_stall = hazard_s;
   // A flush discards the fetched word too, so nothing is accepted on that edge.
   assign in_ready       = ~flush & ~stall & ~hazard_s;

   // ID register and load tracker, in edge priority flush > stall > hazard > advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_instr    <= NOP_INSTR;
         out_pc4      <= 32'h0000_0000;
         ext_sign     <= 1'b1;
         ex_is_load_r <= 1'b0;
         ex_rt_r      <= 5'd0;
      end else if (flush) begin
         out_valid    <= 1'b0;
         out_instr    <= NOP_INSTR;
         out_pc4      <= 32'h0000_0000;
         ext_sign     <= 1'b1;
         ex_is_load_r <= 1'b0;
         ex_rt_r      <= 5'd0;
      end else if (stall) begin
         out_valid    <= out_valid;
         out_instr    <= out_instr;
         out_pc4      <= out_pc4;
         ext_sign     <= ext_sign;
         ex_is_load_r <= ex_is_load_r;
         ex_rt_r      <= ex_rt_r;
      end else if (hazard_s) begin
         // The dependent instruction stays in ID. The bubble goes into EX,
         // so the tracker no longer sees a load. This limits each load to one bubble.
         out_valid    <= out_valid;
         out_instr    <= out_instr;
         out_pc4      <= out_pc4;
         ext_sign     <= ext_sign;
         ex_is_load_r <= 1'b0;
         ex_rt_r      <= ex_rt_r;
      end else begin
         out_valid    <= in_valid;
         out_instr    <= cap_instr_s;
         out_pc4      <= in_pc4;
         ext_sign     <= cap_sign_s;
         ex_is_load_r <= out_valid & (opcode == 6'h23);
         ex_rt_r      <= rt;
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
// This bench sends directed and randomized traffic through if_id_stage. It
// compares every output with a reference model of the pipeline-register rules
// that is kept inside the bench.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   localparam logic [31:0] I_LW2   = 32'h8C22_0000; // lw   $2,0($1)
   localparam logic [31:0] I_ADD   = 32'h0044_1820; // add  $3,$2,$4
   localparam logic [31:0] I_LW0   = 32'h8C20_0000; // lw   $0,0($1)
   localparam logic [31:0] I_RD0   = 32'h0000_1820; // add  $3,$0,$0
   localparam logic [31:0] I_ADDI  = 32'h20C5_0001; // addi $5,$6,1
   localparam logic [31:0] I_ANDI  = 32'h3042_00FF;
   localparam logic [31:0] I_ADDI2 = 32'h2042_8EF0;
   localparam logic [31:0] I_OR    = 32'h00E8_4825; // or   $9,$7,$8
   localparam logic [31:0] I_SUB   = 32'h014B_6022; // sub  $12,$10,$11

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc4;
   logic        stall;
   logic        flush;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc4;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic        ext_sign;
   logic        load_use_stall;

   int checks = 0;
   int errors = 0;

   // Reference model: the contents of ID plus the memory of the instruction that just moved to EX.
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_sign;
   logic        m_load;
   logic [4:0]  m_rt;

   if_id_stage #(.NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
      .in_pc4(in_pc4), .stall(stall), .flush(flush), .in_ready(in_ready),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc4(out_pc4),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm16(imm16),
      .ext_sign(ext_sign), .load_use_stall(load_use_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic model_hazard();
      logic [5:0] op;
      logic       reads_rt;
      op       = m_instr[31:26];
      reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
      return m_valid && m_load && (m_rt != 5'd0) &&
             ((m_rt == m_instr[25:21]) || (reads_rt && (m_rt == m_instr[20:16])));
   endfunction

   function automatic logic zero_ext_op(input logic [5:0] op);
      return (op >= 6'h0C) && (op <= 6'h0F);
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_instr = NOP; m_pc4 = 32'h0; m_sign = 1'b1;
      m_load = 1'b0;  m_rt = 5'd0;
   endtask

   task automatic model_edge(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                             input logic st, input logic fl);
      logic hz;
      hz = model_hazard();
      if (fl) begin
         model_reset();
      end else if (st) begin
         m_valid = m_valid;
      end else if (hz) begin
         m_load = 1'b0;
      end else begin
         m_load  = m_valid && (m_instr[31:26] == 6'h23);
         m_rt    = m_instr[20:16];
         m_valid = v;
         m_instr = v ? ins : NOP;
         m_pc4   = pc;
         m_sign  = !zero_ext_op(m_instr[31:26]);
      end
   endtask

   task automatic check_regs();
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_instr", out_instr, m_instr);
      if (m_valid) begin
         chk("out_pc4", out_pc4, m_pc4);
         chk("ext_sign", 32'(ext_sign), 32'(m_sign));
      end
      chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
      chk("rs", 32'(rs), 32'(m_instr[25:21]));
      chk("rt", 32'(rt), 32'(m_instr[20:16]));
      chk("rd", 32'(rd), 32'(m_instr[15:11]));
      chk("funct", 32'(funct), 32'(m_instr[5:0]));
      chk("imm16", 32'(imm16), 32'(m_instr[15:0]));
   endtask

   // One clock: drive inputs just after the falling edge, check the combinational
   // outputs, take the rising edge, then check the registered state at the next falling edge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic st, input logic fl);
      in_valid = v; in_instr = ins; in_pc4 = pc; stall = st; flush = fl;
      #1;
      chk("load_use_stall", 32'(load_use_stall), 32'(model_hazard()));
      if (!fl) chk("in_ready", 32'(in_ready), 32'(!st && !model_hazard()));
      @(posedge clk);
      model_edge(v, ins, pc, st, fl);
      @(negedge clk);
      check_regs();
   endtask

   task automatic reset_mid();
      #2;
      in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_instr", out_instr, NOP);
      chk("rst_out_pc4", out_pc4, 32'h0);
      chk("rst_ext_sign", 32'(ext_sign), 32'h1);
      chk("rst_load_use_stall", 32'(load_use_stall), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] op;
      case ($urandom_range(0, 8))
         0, 1:    op = 6'h23;
         2:       op = 6'h00;
         3:       op = 6'h04;
         4:       op = 6'h05;
         5:       op = 6'h2B;
         6:       op = 6'h0C;
         7:       op = 6'h0F;
         default: op = 6'h08;
      endcase
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              16'($urandom)};
   endfunction

   initial begin
      logic        was_ready;
      logic        hv;
      logic [31:0] hi;
      logic [31:0] hp;
      logic        st;
      logic        fl;

      rst_n = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc4 = 32'h0;
      stall = 1'b0; flush = 1'b0;
      model_reset();
      @(negedge clk);
      reset_mid();

      // Extension select
      cycle(1'b1, I_ANDI, 32'h0000_0104, 1'b0, 1'b0);
      chk("andi_imm16", 32'(imm16), 32'h0000_00FF);
      chk("andi_ext_sign", 32'(ext_sign), 32'h0);
      chk("andi_pc4", out_pc4, 32'h0000_0104);
      cycle(1'b1, I_ADDI2, 32'h0000_0108, 1'b0, 1'b0);
      chk("addi_ext_sign", 32'(ext_sign), 32'h1);
      chk("addi_imm16", 32'(imm16), 32'h0000_8EF0);

      // Load-use hazard: one bubble, then add advances
      cycle(1'b1, I_LW2, 32'h0000_010C, 1'b0, 1'b0);
      cycle(1'b1, I_ADD, 32'h0000_0110, 1'b0, 1'b0);
      chk("lu_stall_on", 32'(load_use_stall), 32'h1);
      cycle(1'b1, I_OR, 32'h0000_0114, 1'b0, 1'b0);
      chk("lu_add_held", out_instr, I_ADD);
      chk("lu_stall_off", 32'(load_use_stall), 32'h0);
      cycle(1'b1, I_OR, 32'h0000_0114, 1'b0, 1'b0);
      chk("lu_next_accepted", out_instr, I_OR);

      // Load into $0 never stalls
      cycle(1'b1, I_LW0, 32'h0000_0118, 1'b0, 1'b0);
      cycle(1'b1, I_RD0, 32'h0000_011C, 1'b0, 1'b0);
      chk("lw0_no_stall", 32'(load_use_stall), 32'h0);
      // lw $2 followed by an unrelated addi
      cycle(1'b1, I_LW2, 32'h0000_0120, 1'b0, 1'b0);
      cycle(1'b1, I_ADDI, 32'h0000_0124, 1'b0, 1'b0);
      chk("lw_addi_no_stall", 32'(load_use_stall), 32'h0);

      // Flush beats both stall and a pending hazard
      cycle(1'b1, I_LW2, 32'h0000_0128, 1'b0, 1'b0);
      cycle(1'b1, I_ADD, 32'h0000_012C, 1'b0, 1'b0);
      chk("fl_hazard_pending", 32'(load_use_stall), 32'h1);
      cycle(1'b1, I_OR, 32'h0000_0130, 1'b1, 1'b1);
      chk("fl_out_valid", 32'(out_valid), 32'h0);
      chk("fl_out_instr", out_instr, NOP);
      chk("fl_ext_sign", 32'(ext_sign), 32'h1);
      chk("fl_no_hazard", 32'(load_use_stall), 32'h0);

      // External stall for three cycles
      cycle(1'b1, I_OR, 32'h0000_0134, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, I_SUB, 32'h0000_0138, 1'b1, 1'b0);
         chk("st_held", out_instr, I_OR);
         chk("st_not_ready", 32'(in_ready), 32'h0);
      end
      cycle(1'b1, I_SUB, 32'h0000_0138, 1'b0, 1'b0);
      chk("st_release_accept", out_instr, I_SUB);

      // A hazard persists while stall holds the tracker
      cycle(1'b1, I_LW2, 32'h0000_013C, 1'b0, 1'b0);
      cycle(1'b1, I_ADD, 32'h0000_0140, 1'b0, 1'b0);
      cycle(1'b1, I_OR, 32'h0000_0144, 1'b1, 1'b0);
      cycle(1'b1, I_OR, 32'h0000_0144, 1'b1, 1'b0);
      chk("hz_persist", 32'(load_use_stall), 32'h1);
      cycle(1'b1, I_OR, 32'h0000_0144, 1'b0, 1'b0);
      chk("hz_cleared", 32'(load_use_stall), 32'h0);
      chk("hz_add_held", out_instr, I_ADD);

      // Idle fetch: an invalid load-shaped word must not create a hazard
      cycle(1'b0, I_LW2, 32'h0000_0148, 1'b0, 1'b0);
      chk("idle_valid", 32'(out_valid), 32'h0);
      chk("idle_instr", out_instr, NOP);
      cycle(1'b1, I_ADD, 32'h0000_014C, 1'b0, 1'b0);
      chk("idle_no_hazard", 32'(load_use_stall), 32'h0);

      // Reset asserted in the middle of a hazard
      cycle(1'b1, I_LW2, 32'h0000_0150, 1'b0, 1'b0);
      cycle(1'b1, I_ADD, 32'h0000_0154, 1'b0, 1'b0);
      reset_mid();

      // Randomized traffic; fetch holds its word while it is not accepted
      was_ready = 1'b1;
      hv = 1'b0; hi = 32'h0; hp = 32'h0;
      for (int i = 0; i < 400; i++) begin
         if (was_ready) begin
            hv = ($urandom_range(0, 5) != 0);
            hi = rand_instr();
            hp = $urandom;
         end
         st = ($urandom_range(0, 5) == 0);
         fl = ($urandom_range(0, 11) == 0);
         was_ready = !fl && !st && !model_hazard();
         cycle(hv, hi, hp, st, fl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch/decode pipeline register for the MIPS core. It captures the fetched instruction and PC+4 and presents decoded fields to the decode stage. That includes the 16-bit immediate and the `sign` select that feed `Sign_extend`. It also detects load-use hazards and stalls fetch for one cycle.

## Interface
- `NOP_INSTR`, default 32'h0000_0000: instruction word loaded on reset, flush and bubble.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: fetch presents a valid instruction.
- `in_instr` input 32: fetched instruction word.
- `in_pc4` input 32: PC+4 of the fetched instruction.
- `stall` input 1: external hold request from later stages.
- `flush` input 1: branch/jump taken; discard the held instruction.
- `in_ready` output 1: the stage accepts `in_instr` at this edge.
- `out_valid` output 1: the ID register holds a real instruction.
- `out_instr` output 32: held instruction word.
- `out_pc4` output 32: held PC+4.
- `opcode` output 6, `rs` output 5, `rt` output 5, `rd` output 5, `funct` output 6: fields of `out_instr`.
- `imm16` output 16: `out_instr[15:0]`; drives `Sign_extend.in`.
- `ext_sign` output 1: drives `Sign_extend.sign`. Value 0 means zero-extend, 1 means sign-extend.
- `load_use_stall` output 1: hazard detected; EX must take a bubble this cycle.

## Operation
- ID register holds `out_valid`, `out_instr` and `out_pc4`.
- Field outputs are combinational slices of `out_instr`.
- `ext_sign` is a registered flag, computed from `in_instr[31:26]` at capture:
  - 0 for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori) and 0x0F (lui).
  - 1 for every other opcode.
- Load tracker registers: `ex_is_load` (1 bit) and `ex_rt` (5 bits). They describe the instruction that left ID on the previous edge.
- Hazard, combinational: `load_use_stall = out_valid & ex_is_load & (ex_rt != 0)`, and one of the following holds:
  - `ex_rt == rs`, or
  - `ex_rt == rt` for opcode 0x00 (R-type), 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- `in_ready = ~stall & ~load_use_stall`; `flush` overrides.
- Edge priority, highest first:
  1. `flush`: load `NOP_INSTR`, set `out_valid=0` and `ext_sign=1`, clear the tracker. This happens even when `stall` or `load_use_stall` is asserted.
  2. `stall`: hold the ID register and the tracker unchanged.
  3. `load_use_stall`: hold the ID register; clear the tracker (`ex_is_load=0`), because the bubble enters EX.
  4. Advance:
     - ID register takes `in_valid`, `in_instr` and `in_pc4`. When `in_valid=0`, load `NOP_INSTR` with `out_valid=0`.
     - Tracker takes `ex_is_load = out_valid & (opcode==0x23)` and `ex_rt = rt` from the outgoing ID contents.
- Stall state machine, derived from the tracker:
  - RUN → HAZARD when the load-use condition holds.
  - HAZARD → RUN unconditionally on the next edge, unless `stall` holds the tracker.
  - A single load causes at most one bubble.

## Timing
- Reset values: `out_valid=0`, `out_instr=NOP_INSTR`, `out_pc4=0`, `ext_sign=1`, `ex_is_load=0`, `ex_rt=0`.
- Derived outputs at reset: `load_use_stall=0` and `in_ready=1` (when `stall=0`).
- Latency: an instruction accepted at edge N appears on all outputs after edge N, within the same cycle.
- `load_use_stall` asserts in the same cycle that the dependent instruction sits in ID. It deasserts after exactly one edge, unless `stall` is high.
- Asserting reset mid-stall or mid-hazard clears everything immediately, with no clock required.
- Fetch must hold `in_instr`/`in_pc4` stable while `in_ready=0`.
- Destination register 0 never causes a hazard.

## Test plan
- Reset and extension select:
  - Assert `rst_n=0` mid-cycle → all outputs take their reset values immediately.
  - Release reset, present `andi` 32'h3042_00FF → next cycle `imm16=16'h00FF`, `ext_sign=0`, `out_pc4` matches.
  - Present `addi` 32'h2042_8EF0 → `ext_sign=1`, `imm16=16'h8EF0`.
- Load-use: `lw $2,0($1)` (32'h8C22_0000) followed by `add $3,$2,$4` (32'h0044_1820):
  - With add in ID, `load_use_stall=1` and `in_ready=0` for one cycle.
  - add stays in ID, then advances.
  - `load_use_stall=0` the following cycle.
- No hazard cases, `load_use_stall=0` throughout:
  - `lw` into `$0` followed by a reader of `$0`.
  - `lw $2` followed by `addi $5,$6,1`.
- Flush priority: assert `flush` together with `stall` and a pending hazard → next cycle `out_valid=0`, `out_instr=NOP_INSTR`, tracker cleared, `load_use_stall=0`.
- External stall:
  - Hold `stall=1` for 3 cycles → `out_instr` unchanged and `in_ready=0`.
  - On release, the next instruction is accepted.
  - An in-progress HAZARD persists until `stall` drops.
- Idle fetch: `in_valid=0` while advancing → `out_valid=0`, `out_instr=NOP_INSTR`, no hazard generated.
